biquad_decimator: RTL and testbench

Downstream stage of the biquad filter. It consumes the filter's signed 8-bit output stream and, for each block of DECIM consecutive accepted samples, emits one block average. Results pass through a 2-entry output FIFO with a valid/ready handshake, so a slower consumer can apply backpressure. Overflow of the FIFO drops the new result and sets a sticky flag.

---
 rtl/biquad_decimator_if.sv | 22 ++
 rtl/biquad_decimator.sv | 124 ++++++++++++
 tb/tb_biquad_decimator.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/biquad_decimator_if.sv
// Sample input, averaged-result output handshake and overrun status of the decimator.
// master = the surrounding environment (drives samples, consumes results); slave = the decimator.
interface biquad_decimator_if #(
   parameter int W = 8
);
   logic         in_en;
   logic [W-1:0] x_in;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         overrun;

   modport master (
      output in_en, x_in, out_ready,
      input  out_data, out_valid, overrun
   );

   modport slave (
      input  in_en, x_in, out_ready,
      output out_data, out_valid, overrun
   );
endinterface

// File: rtl/biquad_decimator.sv
// Block-average decimator: result written to the FIFO on the final sample edge, visible one cycle later.
// Consumer stalls are absorbed by a 2-entry FIFO; a full FIFO drops new results and sets sticky overrun.

// Small synchronous FIFO with registered head: zero-bubble push when full if a pop happens on the same edge.
// Head stays in slot 0; entries shift down on pop, and an emptied FIFO keeps showing the last popped word.
module bqd_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_wr_vld,
   input  logic [W-1:0] i_wr_dat,
   output logic         o_wr_rdy,
   output logic         o_rd_vld,
   output logic [W-1:0] o_rd_dat,
   input  logic         i_rd_rdy
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [CW-1:0] r_count;
   logic          w_pop;
   logic          w_push;
   logic [CW-1:0] w_wr_idx;

   assign w_pop    = (r_count != '0) && i_rd_rdy;
   assign o_wr_rdy = (r_count < CW'(DEPTH)) || w_pop;
   assign w_push   = i_wr_vld && o_wr_rdy;
   assign w_wr_idx = r_count - CW'(w_pop);
   assign o_rd_vld = (r_count != '0);
   assign o_rd_dat = r_mem[0];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         // Shift only occupied slots so slot 0 retains the last popped word when draining to empty.
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_pop && (CW'(i + 1) < r_count)) begin
               r_mem[i] <= r_mem[i + 1];
            end
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (w_wr_idx == CW'(i))) begin
               r_mem[i] <= i_wr_dat;
            end
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

module biquad_decimator #(
   parameter int DECIM = 4,
   parameter int W     = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   biquad_decimator_if.slave   io_bus
);
   localparam int SH = $clog2(DECIM);
   localparam int AW = W + SH;

   logic signed [AW-1:0] r_acc;
   logic [SH-1:0]        r_cnt;
   logic                 r_overrun;

   logic signed [AW-1:0] w_x_ext;
   logic signed [AW-1:0] w_sum;
   logic                 w_final;
   logic [W-1:0]         w_result;
   logic                 w_wr_rdy;
   logic                 w_rd_vld;
   logic [W-1:0]         w_rd_dat;

   // Accumulator is wide enough for DECIM full-scale samples, so the sum never wraps.
   assign w_x_ext  = {{SH{io_bus.x_in[W-1]}}, io_bus.x_in};
   assign w_sum    = r_acc + w_x_ext;
   assign w_final  = io_bus.in_en && (r_cnt == SH'(DECIM - 1));
   assign w_result = W'(w_sum >>> SH);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (io_bus.in_en) begin
            if (w_final) begin
               r_acc <= '0;
               r_cnt <= '0;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + 1'b1;
            end
         end
         if (w_final && !w_wr_rdy) begin
            r_overrun <= 1'b1;
         end
      end
   end

   bqd_fifo #(
      .DEPTH (2),
      .W     (W)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_wr_vld (w_final),
      .i_wr_dat (w_result),
      .o_wr_rdy (w_wr_rdy),
      .o_rd_vld (w_rd_vld),
      .o_rd_dat (w_rd_dat),
      .i_rd_rdy (io_bus.out_ready)
   );

   assign io_bus.out_valid = w_rd_vld;
   assign io_bus.out_data  = w_rd_dat;
   assign io_bus.overrun   = r_overrun;
endmodule

// File: tb/tb_biquad_decimator.sv
// Directed and random stimulus for biquad_decimator, checked every cycle against a queue-based block-average model.
module tb_biquad_decimator;
   localparam int DECIM = 4;
   localparam int W     = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   int   m_blk[$];
   int   m_fifo[$];
   int   m_ovr;

   biquad_decimator_if #(.W(W)) bus ();

   biquad_decimator #(.DECIM(DECIM), .W(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int floor_div(input int s, input int d);
      if (s >= 0) return s / d;
      return -((-s + d - 1) / d);
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: collect accepted samples, average each full block, feed a 2-deep queue.
   task automatic model_step(input bit rst, input bit en, input int x, input bit rdy);
      bit pop;
      bit have;
      int s;
      pop  = rdy && (m_fifo.size() > 0);
      have = 1'b0;
      s    = 0;
      if (rst) begin
         m_blk.delete();
         m_fifo.delete();
         m_ovr = 0;
      end else begin
         if (en) begin
            m_blk.push_back(x);
            if (m_blk.size() == DECIM) begin
               foreach (m_blk[i]) s += m_blk[i];
               have = 1'b1;
               m_blk.delete();
            end
         end
         if (pop) void'(m_fifo.pop_front());
         if (have) begin
            if (m_fifo.size() < 2) m_fifo.push_back(floor_div(s, DECIM));
            else m_ovr = 1;
         end
      end
   endtask

   task automatic cyc(input bit rst, input bit en, input int x, input bit rdy);
      logic [31:0] xv;
      xv            = x;
      rst_n         = !rst;
      bus.in_en     = en;
      bus.x_in      = xv[W-1:0];
      bus.out_ready = rdy;
      @(posedge clk);
      #1;
      model_step(rst, en, x, rdy);
      chk("out_valid", int'(bus.out_valid), int'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) chk("out_data", int'($signed(bus.out_data)), m_fifo[0]);
      chk("overrun", int'(bus.overrun), m_ovr);
   endtask

   task automatic block4(input int a, input int b, input int c, input int d, input bit rdy);
      cyc(0, 1, a, rdy);
      cyc(0, 1, b, rdy);
      cyc(0, 1, c, rdy);
      cyc(0, 1, d, rdy);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_ovr  = 0;
      rst_n  = 1'b0;
      bus.in_en = 1'b0;
      bus.x_in = '0;
      bus.out_ready = 1'b0;

      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("reset_valid", int'(bus.out_valid), 0);
      chk("reset_data", int'(bus.out_data), 0);
      chk("reset_overrun", int'(bus.overrun), 0);

      // Basic block: sum -5 floors to -2, visible right after the 4th sample.
      cyc(0, 1, 10, 1);
      cyc(0, 1, -20, 1);
      cyc(0, 1, 5, 1);
      chk("basic_not_early", int'(bus.out_valid), 0);
      cyc(0, 1, 0, 1);
      chk("basic_valid", int'(bus.out_valid), 1);
      chk("basic_data", int'($signed(bus.out_data)), -2);
      chk("basic_overrun", int'(bus.overrun), 0);

      block4(127, 127, 127, 127, 1);
      chk("max_data", int'($signed(bus.out_data)), 127);
      block4(-128, -128, -128, -128, 1);
      chk("min_data", int'($signed(bus.out_data)), -128);
      block4(50, 50, 50, 51, 1);
      chk("trunc_data", int'($signed(bus.out_data)), 50);
      block4(-1, 0, 0, 0, 1);
      chk("neg_floor_data", int'($signed(bus.out_data)), -1);

      for (int k = 0; k < 4; k++) begin
         cyc(0, 1, 8, 1);
         if (k < 3) begin
            for (int g = 0; g < 3; g++) cyc(0, 0, 100, 1);
         end
      end
      chk("gap_valid", int'(bus.out_valid), 1);
      chk("gap_data", int'($signed(bus.out_data)), 8);
      cyc(0, 0, 0, 1);
      chk("drain_valid", int'(bus.out_valid), 0);

      // Backpressure: third result is dropped.
      block4(1, 1, 1, 1, 0);
      block4(2, 2, 2, 2, 0);
      block4(3, 3, 3, 3, 0);
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_head", int'($signed(bus.out_data)), 1);
      chk("bp_overrun", int'(bus.overrun), 1);
      cyc(0, 0, 0, 1);
      chk("bp_pop1", int'($signed(bus.out_data)), 2);
      cyc(0, 0, 0, 1);
      chk("bp_empty", int'(bus.out_valid), 0);
      chk("bp_sticky", int'(bus.overrun), 1);

      // Push and pop on the same edge while full.
      cyc(1, 0, 0, 0);
      block4(1, 1, 1, 1, 0);
      block4(2, 2, 2, 2, 0);
      cyc(0, 1, 3, 0);
      cyc(0, 1, 3, 0);
      cyc(0, 1, 3, 0);
      cyc(0, 1, 3, 1);
      chk("full_pp_head", int'($signed(bus.out_data)), 2);
      chk("full_pp_overrun", int'(bus.overrun), 0);
      cyc(0, 0, 0, 1);
      chk("full_pp_next", int'($signed(bus.out_data)), 3);
      cyc(0, 0, 0, 1);
      chk("full_pp_empty", int'(bus.out_valid), 0);

      // Partial block discarded by reset.
      cyc(0, 1, 100, 1);
      cyc(0, 1, 100, 1);
      cyc(1, 0, 0, 1);
      chk("mid_rst_valid", int'(bus.out_valid), 0);
      chk("mid_rst_data", int'(bus.out_data), 0);
      cyc(0, 0, 0, 1);
      chk("post_rst_data", int'(bus.out_data), 0);
      chk("post_rst_overrun", int'(bus.overrun), 0);
      block4(4, 4, 4, 4, 1);
      chk("post_rst_result", int'($signed(bus.out_data)), 4);

      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
             int'($urandom_range(0, 255)) - 128, ($urandom_range(0, 9) < 4));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
